// File: rtl/fifo_level.sv
// Synchronous show-ahead FIFO with binary pointers, registered level, threshold flags and flush.
// Optional sticky overflow/underflow flags are built only when FIFO_LEVEL_ERR_EN is defined.
module fifo_level #(
    parameter int DP        = 8,
    parameter int DW        = 32,
    parameter bit CUT_READY = 1'b0,
    parameter int AF_THR    = DP - 1,
    parameter int AE_THR    = 1,
    parameter int LW        = $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          w_req,
    output logic          unfull,
    input  logic [DW-1:0] data_i,
    input  logic          r_req,
    output logic          unempty,
    output logic [DW-1:0] data_o,
    output logic [LW-1:0] level,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          ovf_err,
    output logic          udf_err
);

    localparam int PW = (DP > 1) ? $clog2(DP) : 1;

    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [DW-1:0] mem_q [DP];
    logic          full;
    logic          wen;
    logic          ren;

    // Explicit wrap so non-power-of-two depths never index past DP-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (level_q == LW'(DP));
    assign unempty      = (level_q != '0);
    assign ren          = r_req & unempty & ~flush;
    assign unfull       = CUT_READY ? ~full : (~full | ren);
    assign wen          = w_req & unfull & ~flush;
    assign level        = level_q;
    assign almost_full  = (level_q >= LW'(AF_THR));
    assign almost_empty = (level_q <= LW'(AE_THR));
    assign data_o       = mem_q[rptr_q];

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        level_d = level_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
        end else begin
            if (wen) wptr_d = ptr_inc(wptr_q);
            if (ren) rptr_d = ptr_inc(rptr_q);
            if (wen && !ren) begin
                level_d = level_q + LW'(1);
            end else if (ren && !wen) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
        end
    end

    // Storage is not reset; entries are only observable through the counted level.
    always_ff @(posedge clk) begin
        if (wen) mem_q[wptr_q] <= data_i;
    end

`ifdef FIFO_LEVEL_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (flush) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (w_req && !unfull)  ovf_d = 1'b1;
            if (r_req && !unempty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: two DP=5 instances (CUT_READY=0 and 1) share stimulus and are
// compared every cycle against a shift-array occupancy model; honours FIFO_LEVEL_ERR_EN.
module tb_fifo_level;

    localparam int DP = 5;
    localparam int DW = 8;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int LW = 3;
`ifdef FIFO_LEVEL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          flush;
    logic          w_req;
    logic          r_req;
    logic [DW-1:0] data_i;

    logic          unfull       [2];
    logic          unempty      [2];
    logic [DW-1:0] data_o       [2];
    logic [LW-1:0] level        [2];
    logic          almost_full  [2];
    logic          almost_empty [2];
    logic          ovf_err      [2];
    logic          udf_err      [2];

    int checks   = 0;
    int failures = 0;

    // Reference model: entry 0 is the head; pops shift everything down by one.
    int            cnt  [2];
    logic [DW-1:0] mm   [2][DP];
    bit            movf [2];
    bit            mudf [2];

    fifo_level #(.DP(DP), .DW(DW), .CUT_READY(1'b0), .AF_THR(AF), .AE_THR(AE)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .w_req(w_req), .unfull(unfull[0]),
        .data_i(data_i), .r_req(r_req), .unempty(unempty[0]), .data_o(data_o[0]),
        .level(level[0]), .almost_full(almost_full[0]), .almost_empty(almost_empty[0]),
        .ovf_err(ovf_err[0]), .udf_err(udf_err[0])
    );

    fifo_level #(.DP(DP), .DW(DW), .CUT_READY(1'b1), .AF_THR(AF), .AE_THR(AE)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .w_req(w_req), .unfull(unfull[1]),
        .data_i(data_i), .r_req(r_req), .unempty(unempty[1]), .data_o(data_o[1]),
        .level(level[1]), .almost_full(almost_full[1]), .almost_empty(almost_empty[1]),
        .ovf_err(ovf_err[1]), .udf_err(udf_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            cnt[k]  = 0;
            movf[k] = 1'b0;
            mudf[k] = 1'b0;
        end
    endtask

    // Called just after a falling edge: drive, check pre-edge outputs, advance model, clock once.
    task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
        w_req  = w;
        r_req  = r;
        flush  = f;
        data_i = d;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit full_m = (cnt[k] == DP);
            bit unf_m  = (k == 1) ? !full_m : (!full_m || (r && cnt[k] > 0 && !f));
            chk("level", k, 32'(level[k]), 32'(cnt[k]));
            chk("unempty", k, 32'(unempty[k]), 32'(cnt[k] != 0));
            chk("unfull", k, 32'(unfull[k]), 32'(unf_m));
            chk("almost_full", k, 32'(almost_full[k]), 32'(cnt[k] >= AF));
            chk("almost_empty", k, 32'(almost_empty[k]), 32'(cnt[k] <= AE));
            chk("ovf_err", k, 32'(ovf_err[k]), 32'(movf[k]));
            chk("udf_err", k, 32'(udf_err[k]), 32'(mudf[k]));
            if (cnt[k] > 0) chk("data_o", k, 32'(data_o[k]), 32'(mm[k][0]));
            if (f) begin
                cnt[k]  = 0;
                movf[k] = 1'b0;
                mudf[k] = 1'b0;
            end else begin
                bit wen_m = w && unf_m;
                bit ren_m = r && (cnt[k] > 0);
                if (ERR_EN && w && !unf_m) movf[k] = 1'b1;
                if (ERR_EN && r && cnt[k] == 0) mudf[k] = 1'b1;
                if (ren_m) begin
                    for (int i = 0; i < DP - 1; i++) mm[k][i] = mm[k][i+1];
                    cnt[k]--;
                end
                if (wen_m) begin
                    mm[k][cnt[k]] = d;
                    cnt[k]++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        flush  = 1'b0;
        w_req  = 1'b0;
        r_req  = 1'b0;
        data_i = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state, then fill to full and drain in order.
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hA0 + i));
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        // Pointer wrap past DP-1.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h90 + i));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'hB0 + i));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);

        // Full with simultaneous write and read (instances diverge here).
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hC0 + i));
        step(1, 1, 0, 8'hC5);
        step(1, 1, 0, 8'hC6);
        step(1, 0, 0, 8'hC7);
        step(0, 0, 0, 8'h00);

        // Drain past empty, then write+read into an empty FIFO.
        for (int i = 0; i < 7; i++) step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(1, 1, 0, 8'h55);
        step(0, 0, 0, 8'h00);

        // Flush at level 3 with a concurrent write.
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'hD0 + i));
        step(1, 1, 1, 8'hEE);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);

        // Asynchronous reset mid-operation with a write pending.
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        w_req  = 1'b1;
        data_i = 8'h33;
        rst    = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_level", k, 32'(level[k]), 32'd0);
            chk("rst_unempty", k, 32'(unempty[k]), 32'd0);
            chk("rst_unfull", k, 32'(unfull[k]), 32'd1);
            chk("rst_almost_empty", k, 32'(almost_empty[k]), 32'd1);
            chk("rst_almost_full", k, 32'(almost_full[k]), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        w_req = 1'b0;
        model_clear();
        step(0, 0, 0, 8'h00);

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 24) == 0), 8'($urandom));
        end
        step(0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
